// File: rtl/demux_alu_wb_if.sv
// Write-back bus between the ALU result producer, the demux and the four slot consumers.
// The producer/consumer side uses 'master'; the demux uses 'slave'.
interface demux_alu_wb_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) ();

  logic [WIDTH-1:0] data_in;
  logic [2:0]       sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] o0;
  logic [WIDTH-1:0] o1;
  logic [WIDTH-1:0] o2;
  logic [WIDTH-1:0] o3;
  logic [3:0]       o_valid;
  logic [3:0]       o_ack;
  logic [CNT_W-1:0] drop_cnt;
  logic             sel_err;

  modport master (
    output data_in, sel, in_valid, o_ack,
    input  in_ready, o0, o1, o2, o3, o_valid, drop_cnt, sel_err
  );

  modport slave (
    input  data_in, sel, in_valid, o_ack,
    output in_ready, o0, o1, o2, o3, o_valid, drop_cnt, sel_err
  );

endinterface

// File: rtl/demux_alu_wb.sv
// Write-back demux: steers one ALU result into one of four registered slots,
// each with its own valid/ack handshake; select codes 4..7 are dropped and counted.
//
// Per-slot state table:
//   state | meaning
//   EMPTY | slot holds no unconsumed data, ack is ignored
//   FULL  | slot data waits for its consumer's ack
module demux_alu_wb #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input logic           clk,
  input logic           reset,
  demux_alu_wb_if.slave bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  slot_state_t      state_q [4];
  slot_state_t      state_d [4];
  logic [WIDTH-1:0] data_q  [4];
  logic [3:0]       valid;
  logic [3:0]       wr;
  logic [1:0]       slot_sel;
  logic             routed;
  logic             ready;
  logic             fire;
  logic             discard;
  logic             illegal;
  logic [CNT_W-1:0] drop_q;
  logic             err_q;

  assign slot_sel = bus.sel[1:0];
  assign routed   = !bus.sel[2];

  always_comb begin
    valid = '0;
    for (int k = 0; k < 4; k++) begin
      valid[k] = (state_q[k] == FULL);
    end
  end

  // A full slot can still accept when its consumer takes the old word this same edge.
  always_comb begin
    ready = 1'b1;
    if (routed) begin
      ready = !valid[slot_sel] || bus.o_ack[slot_sel];
    end
  end

  assign fire    = bus.in_valid && ready;
  assign discard = fire && !routed;
  assign illegal = discard && (slot_sel != 2'b00);

  always_comb begin
    wr = '0;
    if (fire && routed) begin
      wr[slot_sel] = 1'b1;
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      state_d[k] = state_q[k];
      case (state_q[k])
        EMPTY: if (wr[k]) state_d[k] = FULL;
        FULL:  if (bus.o_ack[k] && !wr[k]) state_d[k] = EMPTY;
        default: state_d[k] = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (reset) begin
        state_q[k] <= EMPTY;
        data_q[k]  <= '0;
      end else begin
        state_q[k] <= state_d[k];
        if (wr[k]) begin
          data_q[k] <= bus.data_in;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (discard && (drop_q != CNT_MAX)) begin
        drop_q <= drop_q + CNT_ONE;
      end
      if (illegal) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.in_ready = ready;
  assign bus.o0       = data_q[0];
  assign bus.o1       = data_q[1];
  assign bus.o2       = data_q[2];
  assign bus.o3       = data_q[3];
  assign bus.o_valid  = valid;
  assign bus.drop_cnt = drop_q;
  assign bus.sel_err  = err_q;

endmodule

// File: tb/tb_demux_alu_wb.sv
// Self-checking bench for demux_alu_wb: a cycle-by-cycle vector table on an 8-bit
// counter instance, plus hand sequences for saturation (2-bit counter) and reset.
module tb_demux_alu_wb;

  logic clk = 1'b0;
  logic reset_a;
  logic reset_b;
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;

  demux_alu_wb_if #(.WIDTH(8), .CNT_W(8)) bus_a ();
  demux_alu_wb_if #(.WIDTH(8), .CNT_W(2)) bus_b ();

  demux_alu_wb #(.WIDTH(8), .CNT_W(8)) dut_a (
    .clk   (clk),
    .reset (reset_a),
    .bus   (bus_a.slave)
  );

  demux_alu_wb #(.WIDTH(8), .CNT_W(2)) dut_b (
    .clk   (clk),
    .reset (reset_b),
    .bus   (bus_b.slave)
  );

  typedef struct {
    logic       in_valid;
    logic [2:0] sel;
    logic [7:0] data;
    logic [3:0] ack;
    logic       exp_ready;
    logic [3:0] exp_valid;
    logic [7:0] exp_o0;
    logic [7:0] exp_o1;
    logic [7:0] exp_o2;
    logic [7:0] exp_o3;
    logic [7:0] exp_drop;
    logic       exp_err;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    // in, sel, data, ack | ready, valid, o0, o1, o2, o3, drop, err
    vecs[0]  = '{1'b1, 3'd2, 8'h3C, 4'b0000, 1'b1, 4'b0100, 8'h00, 8'h00, 8'h3C, 8'h00, 8'd0, 1'b0};
    vecs[1]  = '{1'b0, 3'd0, 8'h00, 4'b0100, 1'b1, 4'b0000, 8'h00, 8'h00, 8'h3C, 8'h00, 8'd0, 1'b0};
    vecs[2]  = '{1'b1, 3'd1, 8'hA5, 4'b0000, 1'b1, 4'b0010, 8'h00, 8'hA5, 8'h3C, 8'h00, 8'd0, 1'b0};
    vecs[3]  = '{1'b1, 3'd1, 8'h5A, 4'b0000, 1'b0, 4'b0010, 8'h00, 8'hA5, 8'h3C, 8'h00, 8'd0, 1'b0};
    vecs[4]  = '{1'b1, 3'd3, 8'h5A, 4'b0000, 1'b1, 4'b1010, 8'h00, 8'hA5, 8'h3C, 8'h5A, 8'd0, 1'b0};
    vecs[5]  = '{1'b1, 3'd0, 8'h11, 4'b0000, 1'b1, 4'b1011, 8'h11, 8'hA5, 8'h3C, 8'h5A, 8'd0, 1'b0};
    vecs[6]  = '{1'b1, 3'd0, 8'h22, 4'b0001, 1'b1, 4'b1011, 8'h22, 8'hA5, 8'h3C, 8'h5A, 8'd0, 1'b0};
    vecs[7]  = '{1'b1, 3'd4, 8'hFF, 4'b0000, 1'b1, 4'b1011, 8'h22, 8'hA5, 8'h3C, 8'h5A, 8'd1, 1'b0};
    vecs[8]  = '{1'b1, 3'd6, 8'hFF, 4'b0000, 1'b1, 4'b1011, 8'h22, 8'hA5, 8'h3C, 8'h5A, 8'd2, 1'b1};
    vecs[9]  = '{1'b0, 3'd0, 8'h00, 4'b0001, 1'b1, 4'b1010, 8'h22, 8'hA5, 8'h3C, 8'h5A, 8'd2, 1'b1};
    vecs[10] = '{1'b0, 3'd0, 8'h00, 4'b0001, 1'b1, 4'b1010, 8'h22, 8'hA5, 8'h3C, 8'h5A, 8'd2, 1'b1};
    vecs[11] = '{1'b0, 3'd1, 8'h00, 4'b1010, 1'b1, 4'b0000, 8'h22, 8'hA5, 8'h3C, 8'h5A, 8'd2, 1'b1};
    vecs[12] = '{1'b1, 3'd7, 8'h00, 4'b0000, 1'b1, 4'b0000, 8'h22, 8'hA5, 8'h3C, 8'h5A, 8'd3, 1'b1};
    vecs[13] = '{1'b1, 3'd5, 8'h01, 4'b0000, 1'b1, 4'b0000, 8'h22, 8'hA5, 8'h3C, 8'h5A, 8'd4, 1'b1};
    vecs[14] = '{1'b0, 3'd2, 8'h99, 4'b0000, 1'b1, 4'b0000, 8'h22, 8'hA5, 8'h3C, 8'h5A, 8'd4, 1'b1};

    // reset held two edges while a write is offered on both instances
    reset_a = 1'b1;
    reset_b = 1'b1;
    bus_a.in_valid = 1'b1; bus_a.sel = 3'd0; bus_a.data_in = 8'h77; bus_a.o_ack = 4'b0000;
    bus_b.in_valid = 1'b1; bus_b.sel = 3'd0; bus_b.data_in = 8'h77; bus_b.o_ack = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_a = 1'b0;
    reset_b = 1'b0;
    bus_a.in_valid = 1'b0;
    bus_b.in_valid = 1'b0;
    chk("reset_valid", 32'(bus_a.o_valid), 32'h0);
    chk("reset_o0", 32'(bus_a.o0), 32'h0);
    chk("reset_drop", 32'(bus_a.drop_cnt), 32'h0);
    chk("reset_err", 32'(bus_a.sel_err), 32'h0);
    chk("reset_b_valid", 32'(bus_b.o_valid), 32'h0);

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      bus_a.in_valid = vecs[i].in_valid;
      bus_a.sel      = vecs[i].sel;
      bus_a.data_in  = vecs[i].data;
      bus_a.o_ack    = vecs[i].ack;
      #1;
      chk($sformatf("v%0d_ready", i), 32'(bus_a.in_ready), 32'(vecs[i].exp_ready));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", i), 32'(bus_a.o_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("v%0d_o0", i), 32'(bus_a.o0), 32'(vecs[i].exp_o0));
      chk($sformatf("v%0d_o1", i), 32'(bus_a.o1), 32'(vecs[i].exp_o1));
      chk($sformatf("v%0d_o2", i), 32'(bus_a.o2), 32'(vecs[i].exp_o2));
      chk($sformatf("v%0d_o3", i), 32'(bus_a.o3), 32'(vecs[i].exp_o3));
      chk($sformatf("v%0d_drop", i), 32'(bus_a.drop_cnt), 32'(vecs[i].exp_drop));
      chk($sformatf("v%0d_err", i), 32'(bus_a.sel_err), 32'(vecs[i].exp_err));
    end

    // sticky error survives idle cycles
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    bus_a.o_ack    = 4'b0000;
    repeat (10) @(posedge clk);
    #1;
    chk("err_sticky", 32'(bus_a.sel_err), 32'h1);
    chk("drop_idle", 32'(bus_a.drop_cnt), 32'd4);

    // 2-bit counter saturates at 3
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus_b.in_valid = 1'b1;
      bus_b.sel      = 3'd4;
      bus_b.data_in  = 8'hFF;
      @(posedge clk);
      #1;
      chk($sformatf("sat_drop%0d", i), 32'(bus_b.drop_cnt), (i < 3) ? 32'(i + 1) : 32'd3);
    end
    chk("sat_err", 32'(bus_b.sel_err), 32'h0);

    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus_b.sel     = 3'(k);
      bus_b.data_in = 8'h10 + 8'(k);
      @(posedge clk);
    end
    #1;
    chk("fill_valid", 32'(bus_b.o_valid), 32'hF);
    chk("fill_o3", 32'(bus_b.o3), 32'h13);

    // reset wins over a same-cycle write and acks
    @(negedge clk);
    reset_b       = 1'b1;
    bus_b.sel     = 3'd0;
    bus_b.data_in = 8'hEE;
    bus_b.o_ack   = 4'b1111;
    @(posedge clk);
    #1;
    chk("rst_mid_valid", 32'(bus_b.o_valid), 32'h0);
    chk("rst_mid_o0", 32'(bus_b.o0), 32'h0);
    chk("rst_mid_o3", 32'(bus_b.o3), 32'h0);
    chk("rst_mid_drop", 32'(bus_b.drop_cnt), 32'h0);
    @(negedge clk);
    reset_b        = 1'b0;
    bus_b.in_valid = 1'b0;
    bus_b.o_ack    = 4'b0000;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
